// File: rtl/cp_insert.sv
// cp_insert: transmit-side cyclic-prefix inserter.
// Collects N-sample symbols into a ping-pong buffer and replays each one as
// its last L samples (the prefix) followed by the whole symbol.
// Optional feature macro: CP_BYPASS_EN adds a cp_bypass input that lets a
// symbol skip its prefix.
module cp_insert #(
  parameter int N = 256,
  parameter int L = 16,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] tx_re_in,
  input  logic [W-1:0] tx_img_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_real,
  output logic [W-1:0] out_imag,
  output logic         out_sop,
  output logic         out_eop
`ifdef CP_BYPASS_EN
  ,
  input  logic         cp_bypass
`endif
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] CP_START = IW'(N - L);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, CP, BODY} rd_state_e;

  // Ping-pong storage, one bank per symbol.
  logic [W-1:0] mem_re [2][N];
  logic [W-1:0] mem_im [2][N];

  logic          wr_bank;
  logic [IW-1:0] wr_idx;
  logic [1:0]    bank_full;

  rd_state_e     state, state_nxt;
  logic [IW-1:0] rd_idx, idx_nxt;
  logic          rd_bank, bank_nxt;
  logic          bypassed, byp_nxt;

  rd_state_e     eff_state;
  logic [IW-1:0] eff_idx;
  logic          eff_byp;
  logic          bypass_req;
  logic          load, emit, o_sop, o_eop, rel_bank;
  logic          accept, wr_last;

`ifdef CP_BYPASS_EN
  assign bypass_req = cp_bypass;
`else
  assign bypass_req = 1'b0;
`endif

  assign in_ready = !bank_full[wr_bank];
  assign accept   = in_valid && in_ready;
  assign wr_last  = accept && (wr_idx == LAST_IDX);
  assign load     = !out_valid || out_ready;

  // Write pointer and bank occupancy; set and release act on their own bits.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_bank   <= 1'b0;
      wr_idx    <= '0;
      bank_full <= 2'b00;
    end else begin
      if (accept) begin
        wr_idx <= wr_last ? '0 : wr_idx + 1'b1;
        if (wr_last) wr_bank <= ~wr_bank;
      end
      bank_full <= (bank_full & ~(2'(rel_bank) << rd_bank))
                 | (2'(wr_last) << wr_bank);
    end
  end

  // Sample storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; its contents are only read after being
    // written, so clearing it would add logic with no functional effect.
    if (accept) begin
      mem_re[wr_bank][wr_idx] <= tx_re_in;
      mem_im[wr_bank][wr_idx] <= tx_img_in;
    end
  end

  // Read state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_idx   <= '0;
      rd_bank  <= 1'b0;
      bypassed <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_idx   <= idx_nxt;
      rd_bank  <= bank_nxt;
      bypassed <= byp_nxt;
    end
  end

  // Effective read position: IDLE with a full bank starts the symbol in the
  // same cycle, which keeps the first-output latency at two cycles.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    eff_state = state;
    eff_idx   = rd_idx;
    eff_byp   = bypassed;
    if (state == IDLE && bank_full[rd_bank]) begin
      eff_byp   = bypass_req;
      eff_state = bypass_req ? BODY : CP;
      eff_idx   = bypass_req ? '0 : CP_START;
    end
  end

  // Next-state logic: advance one sample per load.
  always_comb begin
    state_nxt = state;
    idx_nxt   = rd_idx;
    bank_nxt  = rd_bank;
    byp_nxt   = bypassed;
    if (emit) begin
      byp_nxt = eff_byp;
      case (eff_state)
        CP: begin
          state_nxt = (eff_idx == LAST_IDX) ? BODY : CP;
          idx_nxt   = eff_idx + 1'b1;
        end
        BODY: begin
          state_nxt = BODY;
          idx_nxt   = eff_idx + 1'b1;
          if (eff_idx == LAST_IDX) begin
            bank_nxt = ~rd_bank;
            if (bank_full[~rd_bank]) begin
              byp_nxt   = bypass_req;
              state_nxt = bypass_req ? BODY : CP;
              idx_nxt   = bypass_req ? '0 : CP_START;
            end else begin
              byp_nxt   = 1'b0;
              state_nxt = IDLE;
              idx_nxt   = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: framing flags and bank release for the sample being loaded.
  always_comb begin
    emit     = load && (eff_state != IDLE);
    o_sop    = (eff_state == CP && eff_idx == CP_START)
            || (eff_state == BODY && eff_idx == '0 && eff_byp);
    o_eop    = (eff_state == BODY) && (eff_idx == LAST_IDX);
    rel_bank = emit && o_eop;
  end

  // Output register: refilled on load, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
    end else if (load) begin
      out_valid <= emit;
      out_sop   <= emit && o_sop;
      out_eop   <= emit && o_eop;
      if (emit) begin
        out_real <= mem_re[rd_bank][eff_idx];
        out_imag <= mem_im[rd_bank][eff_idx];
      end
    end
  end

endmodule

// File: tb/tb_cp_insert.sv
// tb_cp_insert: scoreboard bench for cp_insert with N=8, L=2.
// Completed input symbols are expanded into expected output sequences by a
// symbol-level model; a monitor pops and compares on every output handshake.
module tb_cp_insert;
  localparam int N = 8;
  localparam int L = 2;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] tx_re_in = '0;
  logic [W-1:0] tx_img_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_real, out_imag;
  logic         out_sop, out_eop;
  logic         cp_bypass = 1'b0;

  cp_insert #(.N(N), .L(L), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .tx_re_in(tx_re_in), .tx_img_in(tx_img_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag),
    .out_sop(out_sop), .out_eop(out_eop)
`ifdef CP_BYPASS_EN
    , .cp_bypass(cp_bypass)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [33:0]  exp_q[$];          // {sop, eop, re, im}
  logic [W-1:0] acc_re[N], acc_im[N];
  int           acc_n = 0;
  logic         sym_byp = 1'b0;
  int           last_acc_cyc = 0;
  int           first_valid_cyc = -1;
  int           last_valid_cyc = 0;
  int           out_count = 0;
  logic         saw_stall = 1'b0;
  logic         rand_ready = 1'b0;
  logic         stalled = 1'b0;
  logic [34:0]  held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Input monitor + reference model: a completed symbol expands to prefix
  // (last L samples) then body, or body only when bypassed.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (in_valid && in_ready) begin
        acc_re[acc_n] = tx_re_in;
        acc_im[acc_n] = tx_img_in;
        acc_n++;
        if (acc_n == N) begin
          if (!sym_byp)
            for (int i = N - L; i < N; i++)
              exp_q.push_back({(i == N - L), 1'b0, acc_re[i], acc_im[i]});
          for (int i = 0; i < N; i++)
            exp_q.push_back({(sym_byp && i == 0), (i == N - 1), acc_re[i], acc_im[i]});
          acc_n = 0;
          last_acc_cyc = cyc;
        end
      end
    end
  end

  // Output monitor: hold check while stalled, scoreboard compare on handshake.
  always @(negedge clk) begin
    logic [34:0] cur;
    logic [33:0] exp;
    cur = {out_valid, out_sop, out_eop, out_real, out_imag};
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("hold", 64'(cur), 64'(held));
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(cur[33:0]), 64'h0_dead_beef);
        end else begin
          exp = exp_q.pop_front();
          check("out_sample", 64'(cur[33:0]), 64'(exp));
        end
        out_count++;
        last_valid_cyc = cyc;
      end
      stalled = out_valid && !out_ready;
      held    = cur;
    end
  end

  task automatic send_sample(input logic [W-1:0] re, input logic [W-1:0] im);
    int guard = 0;
    in_valid  = 1'b1;
    tx_re_in  = re;
    tx_img_in = im;
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL in_ready_timeout: got stalled expected ready");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_symbol(input bit ramp, input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      if (ramp) send_sample(W'(i), W'(16'h100 + i));
      else      send_sample(W'($urandom), W'($urandom));
    end
  endtask

  task automatic drain();
    int g = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #2;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sop",   64'(out_sop),   64'd0);
    check("rst_eop",   64'(out_eop),   64'd0);
    check("rst_data",  64'({out_real, out_imag}), 64'd0);
    exp_q.delete();
    acc_n = 0;
    out_count = 0;
    first_valid_cyc = -1;
    saw_stall = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    // Test 1: reset state.
    repeat (2) @(posedge clk);
    #1 do_reset();

    // Test 2: ramp with out_ready=1, prefix order and latency.
    send_symbol(1'b1, 1'b0);
    drain();
    check("latency", 64'(first_valid_cyc - last_acc_cyc), 64'd2);
    check("t2_count", 64'(out_count), 64'(N + L));

    // Test 3: three back-to-back symbols, contiguous output and back-pressure.
    do_reset();
    for (int s = 0; s < 3; s++) send_symbol(1'b0, 1'b0);
    drain();
    check("t3_count", 64'(out_count), 64'(3 * (N + L)));
    check("t3_contig", 64'(last_valid_cyc - first_valid_cyc + 1), 64'(3 * (N + L)));
    check("t3_backpressure", 64'(saw_stall), 64'd1);

    // Test 4: random output stalls and input gaps.
    rand_ready = 1'b1;
    send_symbol(1'b1, 1'b0);
    for (int s = 0; s < 6; s++) send_symbol(1'b0, 1'b1);
    drain();
    rand_ready = 1'b0;

    // Test 5: reset mid-symbol discards the partial symbol.
    for (int i = 0; i < 5; i++) send_sample(W'(16'h50 + i), W'(i));
    do_reset();
    send_symbol(1'b1, 1'b0);
    drain();
    check("t5_count", 64'(out_count), 64'(N + L));

`ifdef CP_BYPASS_EN
    // Test 6: bypassed symbol then a normal one.
    do_reset();
    sym_byp = 1'b1;
    cp_bypass = 1'b1;
    send_symbol(1'b1, 1'b0);
    drain();
    check("t6_byp_count", 64'(out_count), 64'(N));
    sym_byp = 1'b0;
    cp_bypass = 1'b0;
    out_count = 0;
    send_symbol(1'b1, 1'b0);
    drain();
    check("t6_cp_count", 64'(out_count), 64'(N + L));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
